// File: rtl/prog_counter.sv
// Programmable modulo up/down counter with parallel load, one-shot halt,
// sticky overflow/underflow flags and a wrap pulse. Optional tick prescaler
// is enabled by defining PROG_COUNTER_PRESCALE_EN.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  one_shot,
  input  logic                  clear_flags,
`ifdef PROG_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  terminal,
  output logic                  wrap_pulse,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  running
);

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  if (WIDTH < 2 || PRESCALE_W < 1) begin : g_bad_params
    $error("prog_counter: WIDTH must be >= 2 and PRESCALE_W >= 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             tick;
  logic             at_top;
  logic             at_zero;
  logic             ovf_set;
  logic             unf_set;

  assign at_top  = (count_q >= limit);
  assign at_zero = (count_q == '0);

`ifdef PROG_COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  assign tick = enable && (pcnt_q == prescale);

  // The divider only advances while the counter can actually consume ticks.
  always_comb begin
    pcnt_d = pcnt_q;
    if (load) begin
      pcnt_d = '0;
    end else if (enable && state_q == ST_COUNT) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign tick = enable;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_COUNT;
      count_q     <= '0;
      wrap_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Next-state logic; priority is load > tick > hold.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load) begin
      count_d = load_value;
      state_d = ST_COUNT;
    end else if (state_q == ST_COUNT && tick) begin
      if (up_down) begin
        if (!at_top) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          ovf_set = 1'b1;
          wrap_d  = 1'b1;
          if (one_shot) state_d = ST_HALT;
          else          count_d = '0;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          unf_set = 1'b1;
          wrap_d  = 1'b1;
          if (one_shot) state_d = ST_HALT;
          else          count_d = limit;
        end
      end
    end
    // A set in the same cycle as clear_flags wins.
    overflow_d  = ovf_set | (overflow_q  & ~clear_flags);
    underflow_d = unf_set | (underflow_q & ~clear_flags);
  end

  // Output logic.
  always_comb begin
    running    = (state_q == ST_COUNT);
    terminal   = (up_down && at_top) || (!up_down && at_zero);
    count      = count_q;
    wrap_pulse = wrap_q;
    overflow   = overflow_q;
    underflow  = underflow_q;
  end

endmodule
